im_program_loader: RTL and testbench
====================================

// Module: im_program_loader
// PURPOSE
//   Write side of the byte-wide big-endian instruction memory. Accepts a stream of 32-bit
//   instruction words over a valid/ready handshake and writes each word as 4 byte stores.
//   The MSB byte goes to the lowest address. Holds the core off (busy) during a load and
//   flags completion, so a program can be loaded at run time instead of from an initial block.
// PARAMETERS
//   ADDR_W     6    byte-address width; memory size MEM_BYTES = 2**ADDR_W (64 B = 16 instrs)
//   WCNT_W     5    width of word_count (must hold MEM_BYTES/4)
// PORTS
//   clk         in   1       rising-edge clock (single clock domain)
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       1-cycle pulse; begins a load session (ignored unless IDLE or DONE)
//   base_addr   in   ADDR_W  first byte address; low 2 bits forced to 0 on latch
//   in_valid    in   1       in_data/in_last valid
//   in_data     in   32      instruction word
//   in_last     in   1       marks final word of the program
//   in_ready    out  1       loader can accept a word (high only in ACCEPT)
//   wr_en       out  1       byte write strobe to instruction memory
//   wr_addr     out  ADDR_W  byte address of write
//   wr_data     out  8       byte to write
//   busy        out  1       session in progress (ACCEPT or WRITE); core must stall
//   done        out  1       session finished; held until next start
//   full        out  1       memory end reached before in_last; held until next start
//   word_count  out  WCNT_W  words fully written this session
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE. All outputs 0, including the internal ptr, byte_idx
//   and word registers. Memory contents are not touched, so a partial word stays written.
//   FSM states: IDLE, ACCEPT, WRITE, DONE.
//   IDLE/DONE + start:
//     - ptr <= {base_addr[ADDR_W-1:2],2'b00}.
//     - word_count, done and full cleared.
//     - go to ACCEPT.
//   start in ACCEPT/WRITE: ignored.
//   ACCEPT: in_ready=1 (combinational from state). On in_valid&&in_ready: latch in_data and
//     in_last, byte_idx<=0, go to WRITE.
//   WRITE: 4 consecutive cycles with wr_en=1.
//     - All wr_* outputs are registered; the first byte appears the cycle after the handshake.
//     - wr_addr = ptr+byte_idx.
//     - wr_data = word[31-8*byte_idx -: 8]: byte 0 = bits [31:24] (big-endian).
//     - On byte_idx==3: ptr<=ptr+4 (mod MEM_BYTES) and word_count++. Then:
//       - latched last=1 -> DONE, done=1.
//       - else ptr+4 wraps to 0 -> DONE, done=1, full=1 (no wrap-around write).
//       - else -> ACCEPT.
//   Throughput: 1 word per 5 cycles minimum; in_valid stalls extend ACCEPT indefinitely.
//   wr_en=0 in all states other than WRITE; wr_addr/wr_data hold their last value.
//   busy = (state==ACCEPT||state==WRITE).
//   in_last on a word that also fills memory: done=1, full=0.
// CONFIGURATION
//   IM_LOADER_CHECKSUM_EN defined:
//     - adds output checksum[31:0], reset 0, cleared on accepted start.
//     - XOR-accumulates each word when its 4th byte is written.
//   Undefined: no port and no logic.
// STRUCTURE
//   Package im_loader_pkg: state enum, BYTES_PER_INSTR=4, MEM_BYTES localparam helper.
//   One sub-module: im_word_serializer (latches 32-bit word, 2-bit byte_idx counter,
//     emits big-endian byte + last-byte flag). The top-level module holds the FSM, ptr,
//     counters and flags.
// TESTING
//   1. start, base 0, word 0xF8400182 with last=1 -> cycles +1..+4: F8@0, 40@1, 01@2, 82@3;
//      then done=1, word_count=1, busy=0.
//   2. base_addr=6 -> first wr_addr=4. Two words 0xAA010285, 0x8A1B0386 (last on 2nd)
//      -> addrs 4..11 in order, word_count=2.
//   3. base 60, two words without last -> bytes written @60..63 only; full=1, done=1,
//      in_ready=0, 2nd word not accepted.
//   4. rst_n low after 2nd byte of a word -> all outputs 0 immediately (async); IDLE;
//      in_ready=0; no further wr_en.
//   5. start pulsed during WRITE -> ignored; the session completes unchanged.
//      in_valid gaps of 3 cycles -> no writes during the gaps.
//   6. IM_LOADER_CHECKSUM_EN: words 0xAA010285, 0x8A1B0386 -> checksum=0x201A0103.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package im_loader_pkg;

  localparam int BYTES_PER_INSTR = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int mem_bytes(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Big-endian byte select: index 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/im_word_serializer.sv
// Latches one instruction word and steps through its bytes MSB first.
// The word output exists only when IM_LOADER_CHECKSUM_EN is defined.
module im_word_serializer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        advance,
  output logic [7:0]  byte_data,
  output logic        last_byte
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] word
`endif
);

  logic [31:0] word_q;
  logic [1:0]  byte_idx;

  // byte_data is registered one step ahead so it lines up with the registered write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      byte_idx  <= '0;
      byte_data <= '0;
    end else if (load) begin
      word_q    <= load_word;
      byte_idx  <= 2'd0;
      byte_data <= be_byte(load_word, 2'd0);
    end else if (advance) begin
      byte_idx  <= byte_idx + 2'd1;
      byte_data <= be_byte(word_q, byte_idx + 2'd1);
    end
  end

  assign last_byte = (byte_idx == 2'd3);

`ifdef IM_LOADER_CHECKSUM_EN
  assign word = word_q;
`endif

endmodule

// File: rtl/im_program_loader.sv
// Write side of the byte-wide big-endian instruction memory: session FSM, pointer and flags.
// Optional XOR checksum output when IM_LOADER_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | no session since reset
// ACCEPT | waiting for the next word (in_ready=1)
// WRITE  | emitting the 4 byte stores of the latched word
// DONE   | session ended (last word or memory end); waits for start
module im_program_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int WCNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [WCNT_W-1:0] word_count
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              last_q;
  logic              handshake;
  logic              advance;
  logic              last_byte;
  logic              start_ok;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       ser_word;
`endif

  assign in_ready  = (state == ST_ACCEPT);
  assign busy      = (state == ST_ACCEPT) || (state == ST_WRITE);
  assign handshake = in_ready && in_valid;
  assign advance   = (state == ST_WRITE) && !last_byte;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign ptr_next  = ptr + ADDR_W'(BYTES_PER_INSTR);

  im_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (handshake),
    .load_word (in_data),
    .advance   (advance),
    .byte_data (wr_data),
    .last_byte (last_byte)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .word      (ser_word)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      last_q     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            ptr        <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            state      <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            last_q  <= in_last;
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (last_byte) begin
            wr_en      <= 1'b0;
            ptr        <= ptr_next;
            word_count <= word_count + WCNT_W'(1);
            if (last_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (ptr_next == '0) begin
              // Memory end reached without in_last: stop rather than wrap onto address 0.
              done  <= 1'b1;
              full  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_ACCEPT;
            end
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if ((state == ST_WRITE) && last_byte) begin
      checksum <= checksum ^ ser_word;
    end
  end
`endif

endmodule

// File: tb/tb_im_program_loader.sv
// Self-checking bench for im_program_loader: directed scenarios plus randomized sessions
// checked against a byte-stream model of the load session.
module tb_im_program_loader;
  import im_loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int WCNT_W = 5;
  localparam int MEMB   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready, wr_en, busy, done, full;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [WCNT_W-1:0] word_count;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [13:0] obs_q[$];
  logic [13:0] exp_q[$];
  logic [31:0] stim_words[$];

  always #5 clk = ~clk;

  im_program_loader #(.ADDR_W(ADDR_W), .WCNT_W(WCNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .word_count (word_count)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always @(negedge clk) begin
    if (rst_n && wr_en) obs_q.push_back({wr_addr, wr_data});
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({wr_en, wr_addr, wr_data, busy, done, full, in_ready, word_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b done=%b full=%b rdy=%b wc=%0d, need all 0",
               wr_en, wr_addr, wr_data, busy, done, full, in_ready, word_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_timing();
    logic [7:0] exp_b;
    int k;
    obs_q.delete();
    pulse_start(6'd0);
    in_valid = 1'b1;
    in_data = 32'hF840_0182;
    in_last = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 50);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      exp_b = be_byte(32'hF840_0182, 2'(b));
      tests_run++;
      if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(b) || wr_data !== exp_b) begin
        tests_failed++;
        $display("FAIL single_byte%0d: got en=%b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 b, wr_en, wr_addr, wr_data, b, exp_b);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || word_count !== WCNT_W'(1) || busy !== 1'b0 || wr_en !== 1'b0 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_end: got done=%b wc=%0d busy=%b en=%b full=%b, need done=1 wc=1 busy=0 en=0 full=0",
               done, word_count, busy, wr_en, full);
    end
  endtask

  // Runs one session over stim_words; last_idx = index carrying in_last (-1 for none).
  task automatic run_session(input logic [ADDR_W-1:0] base, input int last_idx,
                             input int max_gap, input bit poke, input string name);
    int addr, n_exp, k, nobs;
    bit full_exp;
    logic [31:0] cks_exp;
    exp_q.delete();
    addr = int'(base) & ~3;
    n_exp = 0;
    full_exp = 1'b0;
    cks_exp = '0;
    for (int i = 0; i < stim_words.size(); i++) begin
      for (int b = 0; b < 4; b++)
        exp_q.push_back({ADDR_W'(addr + b), stim_words[i][31-8*b -: 8]});
      addr += 4;
      n_exp++;
      cks_exp ^= stim_words[i];
      if (i == last_idx) break;
      if (addr == MEMB) begin full_exp = 1'b1; break; end
    end

    obs_q.delete();
    pulse_start(base);
    for (int i = 0; i < n_exp; i++) begin
      repeat ($urandom_range(max_gap, 0)) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data = stim_words[i];
      in_last = (i == last_idx);
      k = 0;
      do begin @(negedge clk); k++; end while (!in_ready && k < 100);
      if (!in_ready) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s_accept_timeout: word %0d never accepted", name, i);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (poke && i == 0) begin
        start = 1'b1;
        base_addr = ADDR_W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end

    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 100);
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, need 1", name, done, k);
    end

    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s_write_count: got %0d byte writes, need %0d", name, obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      tests_run++;
      if (obs_q[j] !== exp_q[j]) begin
        tests_failed++;
        $display("FAIL %s_write%0d: got addr=%0d data=%h, need addr=%0d data=%h", name, j,
                 obs_q[j][13:8], obs_q[j][7:0], exp_q[j][13:8], exp_q[j][7:0]);
      end
    end

    tests_run++;
    if (word_count !== WCNT_W'(n_exp) || full !== full_exp || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_flags: got wc=%0d full=%b busy=%b, need wc=%0d full=%b busy=0",
               name, word_count, full, busy, n_exp, full_exp);
    end
`ifdef IM_LOADER_CHECKSUM_EN
    tests_run++;
    if (checksum !== cks_exp) begin
      tests_failed++;
      $display("FAIL %s_checksum: got %h, need %h", name, checksum, cks_exp);
    end
`endif

    // A further offered word must not be taken once the session has ended.
    nobs = obs_q.size();
    #1;
    in_valid = 1'b1;
    in_data = $urandom;
    in_last = 1'b0;
    k = 0;
    repeat (3) begin @(negedge clk); if (in_ready) k++; end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (k != 0 || obs_q.size() != nobs || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_after_done: got ready_cycles=%0d extra_writes=%0d done=%b, need 0 0 1",
               name, k, obs_q.size() - nobs, done);
    end
  endtask

  task automatic test_two_words();
    stim_words = '{32'hAA01_0285, 32'h8A1B_0386};
    run_session(6'd6, 1, 0, 1'b0, "two_words");
`ifdef IM_LOADER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 32'h201A_0103) begin
      tests_failed++;
      $display("FAIL checksum_fixed: got %h, need 201a0103", checksum);
    end
`endif
  endtask

  task automatic test_full();
    stim_words = '{32'h1234_5678, 32'h9ABC_DEF0};
    run_session(6'd60, -1, 0, 1'b0, "full");
    stim_words = '{32'h0102_0304, 32'hA5A5_5A5A};
    run_session(6'd56, 1, 1, 1'b0, "last_at_end");
  endtask

  task automatic test_start_during_write();
    stim_words = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_1234};
    run_session(6'd20, 2, 3, 1'b1, "start_ignored");
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] base;
    int n, last_idx;
    for (int s = 0; s < 8; s++) begin
      base = ADDR_W'($urandom);
      if (s % 3 == 2) begin
        n = (MEMB - (int'(base) & ~3)) / 4 + 1;
        last_idx = -1;
      end else begin
        n = $urandom_range(6, 1);
        last_idx = n - 1;
      end
      stim_words.delete();
      for (int i = 0; i < n; i++) stim_words.push_back($urandom);
      run_session(base, last_idx, 3, s[0], "rand");
    end
  endtask

  task automatic test_async_reset();
    int k;
    pulse_start(6'd12);
    in_valid = 1'b1;
    in_data = 32'h1122_3344;
    in_last = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 50);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wr_en, wr_addr, wr_data, busy, done, full, in_ready, word_count} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got en=%b addr=%0d data=%h busy=%b done=%b full=%b rdy=%b wc=%0d, need all 0",
               wr_en, wr_addr, wr_data, busy, done, full, in_ready, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    k = 0;
    repeat (10) begin @(negedge clk); if (in_ready || busy) k++; end
    in_valid = 1'b0;
    tests_run++;
    if (obs_q.size() != 0 || k != 0) begin
      tests_failed++;
      $display("FAIL reset_idle: got writes=%0d active_cycles=%0d, need 0 0", obs_q.size(), k);
    end
  endtask

  initial begin
    test_reset();
    test_single_timing();
    test_two_words();
    test_full();
    test_start_during_write();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
